// File: rtl/wei_row_aligner_if.sv
// Purpose : bundles the weight-aligner request/response signals between the
//           index counter / SRAM read port (master) and the aligner (slave).
// Latency : n/a (wiring only).  Backpressure: i_cnt_en acts as a global stall.
//
// Signals (names seen from the aligner):
//   i_cnt_en     pipeline enable, low = stall
//   i_cnt_clear  synchronous clear, wins over i_cnt_en
//   i_waligned   weights row-aligned in memory (single-row windows)
//   i_row_ld     i_sram_data carries a new row this cycle
//   i_sram_data  SRAM row, word k at [k*OP_W +: OP_W]
//   i_woffs      window start word offset
//   i_outbounds  request past tiling end, emit zeros
//   i_done       context done flag, time-aligned with i_woffs
//   o_wei        weight window, weight k at [k*OP_W +: OP_W]
//   o_valid      o_wei valid this cycle
//   o_done       done flag delayed by one enabled cycle
interface wei_row_aligner_if #(
    parameter int OP_W   = 8,
    parameter int WORD_N = 8,
    parameter int WOFS_W = 3,
    parameter int Y      = 4
);
    logic                     i_cnt_en;
    logic                     i_cnt_clear;
    logic                     i_waligned;
    logic                     i_row_ld;
    logic [WORD_N*OP_W-1:0]   i_sram_data;
    logic [WOFS_W-1:0]        i_woffs;
    logic                     i_outbounds;
    logic                     i_done;
    logic [Y*OP_W-1:0]        o_wei;
    logic                     o_valid;
    logic                     o_done;

    // Upstream side: drives the request, observes the window.
    modport master (
        output i_cnt_en,
        output i_cnt_clear,
        output i_waligned,
        output i_row_ld,
        output i_sram_data,
        output i_woffs,
        output i_outbounds,
        output i_done,
        input  o_wei,
        input  o_valid,
        input  o_done
    );

    // Aligner side.
    modport slave (
        input  i_cnt_en,
        input  i_cnt_clear,
        input  i_waligned,
        input  i_row_ld,
        input  i_sram_data,
        input  i_woffs,
        input  i_outbounds,
        input  i_done,
        output o_wei,
        output o_valid,
        output o_done
    );
endinterface

// File: rtl/wei_row_aligner.sv
// Purpose : keeps the last two SRAM weight rows and extracts a Y-word window
//           at an arbitrary word offset, which may straddle a row boundary.
// Latency : 1 cycle from i_woffs to o_wei; a loaded row is usable next cycle.
// Backpressure: i_cnt_en low freezes every register and masks o_valid/o_done.
//
// Ports:
//   i_clk   clock
//   i_rstn  asynchronous active-low reset
//   bus     wei_row_aligner_if.slave (request in, window/valid/done out)
//
// WORD_N must equal 2**WOFS_W so that the aligned-mode offset wraps for free
// in WOFS_W-bit arithmetic; 1 <= Y <= WORD_N keeps the unaligned index within
// the two buffered rows (max index WORD_N+Y-2).
module wei_row_aligner #(
    parameter int OP_W   = 8,
    parameter int WORD_N = 8,
    parameter int WOFS_W = 3,
    parameter int Y      = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    wei_row_aligner_if.slave   bus
);

    localparam int ROW_W = WORD_N * OP_W;
    localparam int WIN_W = Y * OP_W;

    // IDLE : no row buffered since clear/reset.
    // PRIME: one row buffered, unaligned mode still needs the previous row.
    // RUN  : enough rows buffered, every enabled cycle produces a window.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   h_q, h_d;       // newest row
    logic [ROW_W-1:0]   l_q, l_d;       // previous row
    logic [WIN_W-1:0]   wei_q, wei_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    // ------------------------------------------------------------------
    // Window selection, purely from the registered rows: a row loaded on
    // this edge only becomes selectable in the following cycle.
    // ------------------------------------------------------------------
    logic [2*ROW_W-1:0] pair;           // L as words 0..WORD_N-1, H above it
    logic [WIN_W-1:0]   window;

    assign pair = {h_q, l_q};

    for (genvar k = 0; k < Y; k++) begin : g_sel
        // Aligned: offset wraps inside H (WOFS_W-bit add is mod WORD_N).
        logic [WOFS_W-1:0] a_idx;
        // Unaligned: one extra bit addresses the 2*WORD_N word pair; the
        // sum never exceeds WORD_N+Y-2 so no wrap is needed.
        logic [WOFS_W:0]   u_idx;

        assign a_idx = bus.i_woffs + WOFS_W'(k);
        assign u_idx = {1'b0, bus.i_woffs} + (WOFS_W+1)'(k);

        assign window[k*OP_W +: OP_W] = bus.i_waligned
                                      ? h_q[a_idx*OP_W +: OP_W]
                                      : pair[u_idx*OP_W +: OP_W];
    end

    // ------------------------------------------------------------------
    // Next-state logic: FSM, row buffer and output registers.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        l_d     = l_q;
        wei_d   = wei_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (bus.i_cnt_clear) begin
            // Clear behaves exactly like reset and overrides loads/selection.
            state_d = ST_IDLE;
            h_d     = '0;
            l_d     = '0;
            wei_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (bus.i_cnt_en) begin
            if (bus.i_row_ld) begin
                h_d = bus.i_sram_data;
                l_d = h_q;

                unique case (state_q)
                    // An aligned window needs only the newest row, an
                    // unaligned one needs the preceding row as well.
                    ST_IDLE:  state_d = bus.i_waligned ? ST_RUN : ST_PRIME;
                    ST_PRIME: state_d = ST_RUN;
                    ST_RUN:   state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end

            // Out-of-bounds only matters while windows are being produced.
            if (state_q == ST_RUN) begin
                wei_d   = bus.i_outbounds ? '0 : window;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end

            done_d = bus.i_done;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            l_q     <= '0;
            wei_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            l_q     <= l_d;
            wei_q   <= wei_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Valid/done are masked during a stall so the consumer never
    // sees the same beat twice; the window itself simply holds.
    // ------------------------------------------------------------------
    assign bus.o_wei   = wei_q;
    assign bus.o_valid = valid_q & bus.i_cnt_en;
    assign bus.o_done  = done_q  & bus.i_cnt_en;

endmodule

// File: tb/tb_wei_row_aligner.sv
module tb_wei_row_aligner;
    localparam int OP_W   = 8;
    localparam int WORD_N = 8;
    localparam int WOFS_W = 3;
    localparam int Y      = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wei_row_aligner_if #(.OP_W(OP_W), .WORD_N(WORD_N), .WOFS_W(WOFS_W), .Y(Y)) bus ();

    wei_row_aligner #(.OP_W(OP_W), .WORD_N(WORD_N), .WOFS_W(WOFS_W), .Y(Y)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: two rows as word arrays plus a count of rows loaded
    // since the last clear; a window is produced once enough rows exist.
    logic [7:0]  mh [WORD_N];
    logic [7:0]  ml [WORD_N];
    logic [31:0] mwei;
    bit          mvalid, mdone, maligned;
    int          mrows;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkrow(input int base);
        logic [63:0] r;
        for (int w = 0; w < WORD_N; w++) r[w*8 +: 8] = 8'(base + w);
        return r;
    endfunction

    function automatic logic [31:0] model_window(input logic [2:0] wo);
        logic [31:0] r;
        for (int k = 0; k < Y; k++) begin
            int i;
            i = int'(wo) + k;
            if (maligned)    r[k*8 +: 8] = mh[i % WORD_N];
            else if (i < 8)  r[k*8 +: 8] = ml[i];
            else             r[k*8 +: 8] = mh[i - WORD_N];
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int w = 0; w < WORD_N; w++) begin
            mh[w] = '0;
            ml[w] = '0;
        end
        mwei   = '0;
        mvalid = 1'b0;
        mdone  = 1'b0;
        mrows  = 0;
    endtask

    task automatic set_mode(input bit a);
        bus.i_waligned = a;
        maligned       = a;
    endtask

    // One clock cycle: drive, clock, update model, check all outputs.
    task automatic cyc(input bit en, input bit clr, input bit ld, input logic [63:0] row,
                       input logic [2:0] wo, input bit ob, input bit dn);
        bus.i_cnt_en    = en;
        bus.i_cnt_clear = clr;
        bus.i_row_ld    = ld;
        bus.i_sram_data = row;
        bus.i_woffs     = wo;
        bus.i_outbounds = ob;
        bus.i_done      = dn;
        @(posedge clk);
        if (clr) begin
            model_clear();
        end else if (en) begin
            if (mrows >= (maligned ? 1 : 2)) begin
                mwei   = ob ? 32'h0 : model_window(wo);
                mvalid = 1'b1;
            end else begin
                mvalid = 1'b0;
            end
            mdone = dn;
            if (ld) begin
                for (int w = 0; w < WORD_N; w++) begin
                    ml[w] = mh[w];
                    mh[w] = row[w*8 +: 8];
                end
                if (mrows < 2) mrows++;
            end
        end
        #1;
        chk("wei",   bus.o_wei,   mwei);
        chk("valid", bus.o_valid, mvalid & en);
        chk("done",  bus.o_done,  mdone & en);
    endtask

    logic [63:0] row0, row1, rnd;
    logic [31:0] saved;

    initial begin
        row0 = mkrow(8'h00);
        row1 = mkrow(8'h10);
        rstn = 1'b0;
        bus.i_cnt_en    = 1'b0;
        bus.i_cnt_clear = 1'b0;
        bus.i_row_ld    = 1'b0;
        bus.i_sram_data = '0;
        bus.i_woffs     = '0;
        bus.i_outbounds = 1'b0;
        bus.i_done      = 1'b0;
        set_mode(1'b1);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wei",   bus.o_wei,   32'h0);
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_done",  bus.o_done,  1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Aligned mode: one row is enough, offsets wrap inside the row.
        cyc(1, 0, 0, '0, 3'd0, 0, 0);
        cyc(1, 0, 1, row0, 3'd0, 0, 0);
        cyc(1, 0, 0, '0, 3'd4, 0, 0);
        chk("aligned_w4", bus.o_wei, 32'h07060504);
        chk("aligned_w4_valid", bus.o_valid, 1'b1);
        cyc(1, 0, 0, '0, 3'd6, 0, 0);
        chk("aligned_wrap", bus.o_wei, 32'h01000706);

        // Unaligned mode: needs two rows, windows straddle L/H.
        set_mode(1'b0);
        cyc(1, 1, 0, '0, 3'd0, 0, 0);
        cyc(1, 0, 1, row0, 3'd0, 0, 0);
        cyc(1, 0, 1, row1, 3'd0, 0, 0);
        chk("prime_no_valid", bus.o_valid, 1'b0);
        cyc(1, 0, 0, '0, 3'd6, 0, 0);
        chk("straddle_w6", bus.o_wei, 32'h11100706);
        cyc(1, 0, 0, '0, 3'd0, 0, 0);
        chk("unaligned_w0", bus.o_wei, 32'h03020100);

        // Stall for three cycles, one of them presenting a row that must be ignored.
        saved = bus.o_wei;
        cyc(0, 0, 0, '0, 3'd5, 0, 1);
        cyc(0, 0, 1, mkrow(8'h40), 3'd5, 0, 1);
        cyc(0, 0, 0, '0, 3'd5, 1, 1);
        chk("stall_hold_wei", bus.o_wei, saved);
        chk("stall_valid", bus.o_valid, 1'b0);
        chk("stall_done", bus.o_done, 1'b0);
        cyc(1, 0, 0, '0, 3'd7, 0, 0);
        chk("resume_w7", bus.o_wei, 32'h12111007);

        // Out-of-bounds zeros the window but still flags valid; done timing.
        cyc(1, 0, 0, '0, 3'd2, 1, 0);
        chk("outbounds_zero", bus.o_wei, 32'h0);
        chk("outbounds_valid", bus.o_valid, 1'b1);
        cyc(1, 0, 0, '0, 3'd1, 0, 1);
        chk("done_next", bus.o_done, 1'b1);
        bus.i_cnt_en = 1'b0;
        #1;
        chk("done_masked", bus.o_done, 1'b0);
        chk("valid_masked", bus.o_valid, 1'b0);
        bus.i_cnt_en = 1'b1;
        #1;
        chk("done_unmasked", bus.o_done, 1'b1);
        cyc(1, 0, 0, '0, 3'd1, 0, 0);
        chk("done_drop", bus.o_done, 1'b0);

        // Clear beats a simultaneous load; two fresh rows are needed again.
        cyc(1, 1, 1, mkrow(8'h50), 3'd3, 0, 1);
        chk("clear_wei", bus.o_wei, 32'h0);
        chk("clear_valid", bus.o_valid, 1'b0);
        cyc(1, 0, 1, mkrow(8'h60), 3'd3, 0, 0);
        cyc(1, 0, 1, mkrow(8'h70), 3'd3, 0, 0);
        chk("clear_prime", bus.o_valid, 1'b0);
        cyc(1, 0, 0, '0, 3'd5, 0, 0);
        chk("clear_refill", bus.o_wei, 32'h70676665);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_wei", bus.o_wei, 32'h0);
        chk("arst_valid", bus.o_valid, 1'b0);
        chk("arst_done", bus.o_done, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc(1, 0, 0, '0, 3'd2, 0, 0);
        cyc(1, 0, 0, '0, 3'd2, 0, 0);
        cyc(1, 0, 1, row0, 3'd2, 0, 0);
        chk("arst_idle", bus.o_valid, 1'b0);

        // Randomized traffic against the model, with occasional mode changes.
        for (int n = 0; n < 400; n++) begin
            rnd = {$urandom, $urandom};
            if ($urandom_range(0, 39) == 0) begin
                set_mode(1'($urandom_range(0, 1)));
                cyc(1, 1, 1'($urandom_range(0, 1)), rnd, 3'($urandom), 0, 0);
            end else begin
                cyc($urandom_range(0, 4) != 0, 0, $urandom_range(0, 2) == 0, rnd,
                    3'($urandom), $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wei_row_aligner.md
Name: wei_row_aligner

Overview:
- Weight fetch stage directly downstream of the weight index counter and the weight SRAM read port.
- Buffers the last two SRAM rows read and extracts a window of Y consecutive weight words starting at the supplied word offset, so a window may straddle an SRAM row boundary (unaligned weights).
- Registers the window and forwards it with valid, done and out-of-bounds handling to the weight feeder of the systolic array.

Parameters:
- OP_W, 8, width of one weight operand (word) in bits.
- WORD_N, 8, words per SRAM row; must equal 2**WOFS_W.
- WOFS_W, 3, word-offset width.
- Y, 4, weights output per cycle; 1 <= Y <= WORD_N.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_cnt_en  in  1  pipeline enable; low = stall, all state holds.
- i_cnt_clear  in  1  synchronous clear; priority over i_cnt_en.
- i_waligned  in  1  weights aligned in memory (single-row windows).
- i_row_ld  in  1  i_sram_data carries a new row this cycle.
- i_sram_data  in  WORD_N*OP_W  SRAM row; word k at bits [k*OP_W +: OP_W].
- i_woffs  in  WOFS_W  window start word offset.
- i_outbounds  in  1  request is past tiling end; emit zeros.
- i_done  in  1  context done flag, time-aligned with i_woffs.
- o_wei  out  Y*OP_W  weight window; weight k at bits [k*OP_W +: OP_W].
- o_valid  out  1  o_wei valid this cycle.
- o_done  out  1  done, delayed by one enabled cycle.

Behaviour:
- Registers:
  - Row H (newest) and row L (previous), each WORD_N*OP_W bits.
  - State: IDLE, PRIME, RUN.
  - o_wei register; valid_q; done_q.
- Reset (i_rstn low): H, L, o_wei = 0; state IDLE; valid_q = 0; done_q = 0.
- Clear (i_cnt_clear high at a clock edge): same values as reset, independent of i_cnt_en. Clear wins over a simultaneous i_row_ld or selection.
- Row load (i_cnt_en && i_row_ld && !i_cnt_clear): H <= i_sram_data, L <= H.
- FSM transitions (evaluated only when i_cnt_en && i_row_ld):
  - IDLE -> RUN if i_waligned, else IDLE -> PRIME.
  - PRIME -> RUN.
  - RUN stays RUN.
  - No other transitions except clear/reset back to IDLE.
- Window selection (combinational, from the current Q values of H and L, before any same-cycle load):
  - Aligned (i_waligned = 1): weight k = H word[(i_woffs + k) mod WORD_N].
  - Unaligned: form 2*WORD_N words, L as indices 0..WORD_N-1 and H as WORD_N..2*WORD_N-1; weight k = word[i_woffs + k]. The maximum index is WORD_N+Y-2, so no wrap occurs.
- Output register update, when i_cnt_en && !i_cnt_clear:
  - If state == RUN: o_wei <= (i_outbounds ? 0 : window); valid_q <= 1.
  - Else: o_wei holds; valid_q <= 0.
  - done_q <= i_done.
- Output gating:
  - o_valid = valid_q & i_cnt_en.
  - o_done = done_q & i_cnt_en.
  - o_wei is a direct register output and holds its value during a stall.
- Latency: i_woffs sampled at edge t gives o_wei at t+1. A row loaded at edge t is visible to selection from cycle t+1.
- Stall (i_cnt_en low): no register changes; o_valid = o_done = 0; resuming reproduces the pre-stall output sequence.
- i_outbounds with state != RUN: no effect.
- i_row_ld while i_cnt_en low: ignored. The upstream stage re-presents the row.
- i_waligned is static between clears. Changing it mid-context is undefined.

Test Plan:
(WORD_N=8, Y=4, OP_W=8; row0 words = 0x00..0x07, row1 words = 0x10..0x17; o_wei listed from weight 3 down to weight 0)
- Reset: i_rstn low mid-run -> immediately o_wei = 0, o_valid = 0, o_done = 0; after release, state IDLE and no o_valid until a row is loaded.
- Aligned: i_waligned = 1, load row0, next cycle i_woffs = 4 -> following cycle o_wei = {0x07,0x06,0x05,0x04}, o_valid = 1.
- Unaligned straddle: i_waligned = 0, load row0 then row1, then i_woffs = 6 -> o_wei = {0x11,0x10,0x07,0x06}. i_woffs = 0 -> {0x03,0x02,0x01,0x00}. No o_valid after only one row loaded (PRIME).
- Stall: in RUN, i_cnt_en low for 3 cycles, including a cycle with i_row_ld = 1 -> o_valid = 0 and o_done = 0 throughout; H, L and o_wei unchanged; the ignored row is not loaded; resume yields the expected next window.
- Outbounds and done: i_outbounds = 1 with i_woffs = 2 -> o_wei = 0, o_valid = 1. i_done = 1 at edge t -> o_done = 1 in cycle t+1 only while i_cnt_en = 1.
- Clear priority: i_cnt_clear = 1 together with i_cnt_en = 1 and i_row_ld = 1 in RUN -> next cycle state IDLE, H = L = 0, o_valid = 0; two fresh row loads are required before valid output (unaligned mode).
